// File: rtl/seq_hit_window_counter_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_hit_window_counter_if
//  Purpose  : Report handshake bundle between the hit window counter and
//             the status/CSR stage (valid/ready plus report payload).
//  Revision : 1.0 - initial release
// ============================================================================
interface seq_hit_window_counter_if #(
  parameter int CNT_W = 8
);
  logic             rpt_valid;
  logic             rpt_ready;
  logic [CNT_W-1:0] rpt_count;
  logic             rpt_alarm;

  // Producer side: the window counter.
  modport master (
    output rpt_valid,
    output rpt_count,
    output rpt_alarm,
    input  rpt_ready
  );

  // Consumer side: the status/CSR stage.
  modport slave (
    input  rpt_valid,
    input  rpt_count,
    input  rpt_alarm,
    output rpt_ready
  );
endinterface
`default_nettype wire

// File: rtl/seq_hit_window_counter.sv
`default_nettype none
// ============================================================================
//  Module   : seq_hit_window_counter
//  Purpose  : Counts pattern-detector hits over windows of WIN_LEN enabled
//             cycles and queues one report (saturating count + threshold
//             alarm) per window in a 2-entry buffer drained by valid/ready.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_hit_window_counter #(
  parameter int WIN_LEN = 16,
  parameter int CNT_W   = 8,
  parameter int THRESH  = 3
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       en,
  input  wire logic                       hit_in,
  seq_hit_window_counter_if.master        rpt,
  output logic                            drop_flag,
  output logic [$clog2(WIN_LEN)-1:0]      win_pos
);

  localparam int                 c_TW     = $clog2(WIN_LEN);
  localparam logic [c_TW-1:0]    c_LAST   = c_TW'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0]   c_THRESH = CNT_W'(THRESH);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_COUNT = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic             w_count;

  logic [c_TW-1:0]  r_timer;
  logic [CNT_W-1:0] r_acc;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_final;
  logic             w_alarm;
  logic             w_close;

  // Report buffer: entry 0 is the head presented to the consumer.
  logic [1:0]       r_occ;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;
  logic             r_alm0;
  logic             r_alm1;
  logic             r_drop;
  logic             w_pop;
  logic [1:0]       w_occ_pop;
  logic             w_push_ok;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state follows the enable level.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (en)  w_state_nxt = S_COUNT;
      S_COUNT: if (!en) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The cycle en is first sampled high already counts (timer sits at 0).
  always_comb begin
    w_count = 1'b0;
    case (r_state)
      S_IDLE:  w_count = en;
      S_COUNT: w_count = en;
      default: w_count = 1'b0;
    endcase
  end

  // Saturating count including this cycle's hit; used for both accumulate and close.
  always_comb begin
    w_sum   = {1'b0, r_acc} + {{CNT_W{1'b0}}, hit_in};
    w_final = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    w_alarm = (w_final >= c_THRESH);
    w_close = w_count && (r_timer == c_LAST);
  end

  // Window timer and hit accumulator; dropping en discards the partial window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= '0;
      r_acc   <= '0;
    end else if (!w_count || w_close) begin
      r_timer <= '0;
      r_acc   <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
      r_acc   <= w_final;
    end
  end

  // Occupancy after a possible pop decides where a new report lands.
  always_comb begin
    w_pop     = (r_occ != 2'd0) && rpt.rpt_ready;
    w_occ_pop = r_occ - {1'b0, w_pop};
    w_push_ok = w_close && (w_occ_pop != 2'd2);
  end

  // Report FIFO: shift on pop, then write the new report into the first free slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ  <= 2'd0;
      r_cnt0 <= '0;
      r_cnt1 <= '0;
      r_alm0 <= 1'b0;
      r_alm1 <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      if (w_pop) begin
        r_cnt0 <= r_cnt1;
        r_alm0 <= r_alm1;
      end
      if (w_close) begin
        case (w_occ_pop)
          2'd0: begin
            r_cnt0 <= w_final;
            r_alm0 <= w_alarm;
          end
          2'd1: begin
            r_cnt1 <= w_final;
            r_alm1 <= w_alarm;
          end
          default: r_drop <= 1'b1;
        endcase
      end
      r_occ <= w_occ_pop + {1'b0, w_push_ok};
    end
  end

  assign rpt.rpt_valid = (r_occ != 2'd0);
  assign rpt.rpt_count = r_cnt0;
  assign rpt.rpt_alarm = r_alm0;
  assign drop_flag     = r_drop;
  assign win_pos       = r_timer;

endmodule
`default_nettype wire

// File: doc/seq_hit_window_counter.md
Name: seq_hit_window_counter

Overview:
- Downstream consumer of the serial 1011 pattern detector's one-cycle hit pulse.
- Counts detector hits over fixed windows of WIN_LEN enabled cycles.
- At each window end, emits a report word (hit count, threshold alarm) over a valid/ready handshake to the status/CSR stage.
- Reports are held in a 2-entry buffer, so a stalled consumer does not lose results immediately.

Parameters:
- WIN_LEN, 16, cycles per window (>=2).
- CNT_W, 8, width of hit count; count saturates at 2^CNT_W-1.
- THRESH, 3, alarm asserted when window count >= THRESH.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  window counting enable
- hit_in  in  1  detector output; each cycle sampled high counts one hit
- rpt_valid  out  1  report available
- rpt_ready  in  1  consumer accepts report when high with rpt_valid
- rpt_count  out  CNT_W  hits in reported window
- rpt_alarm  out  1  rpt_count >= THRESH
- drop_flag  out  1  sticky: a report was lost because the buffer was full
- win_pos  out  $clog2(WIN_LEN)  current window cycle index

Behaviour:
- Reset (async, rst high):
  - timer=0, hit accumulator=0, both buffer entries empty.
  - rpt_valid=0, rpt_count=0, rpt_alarm=0, drop_flag=0, win_pos=0.
- FSM states:
  - IDLE: en=0; timer and accumulator held at 0; hit_in ignored.
  - COUNT: en=1. IDLE->COUNT on en=1; the first counted cycle is the cycle en is first sampled high (win_pos=0 in that cycle). COUNT->IDLE on en=0.
- Timer, per COUNT cycle:
  - win_pos increments each cycle; wraps WIN_LEN-1 -> 0.
  - accumulator += hit_in, saturating at all-ones.
- Window close (cycle with win_pos==WIN_LEN-1, en=1):
  - Final count = accumulator + hit_in of that same cycle (saturating).
  - The count is pushed as a report on the next edge; the accumulator restarts at 0.
  - A hit in the first cycle of the next window counts for the new window.
- en deasserted mid-window: partial window discarded (timer and accumulator cleared, no report). Queued reports are kept and still drain.
- Report buffer: 2-entry FIFO. The head drives rpt_count/rpt_alarm; rpt_valid = head occupied.
  - Pop when rpt_valid && rpt_ready.
  - Push with pop in the same cycle: always accepted; order preserved.
  - Push into a full buffer without pop: new report dropped, drop_flag set, older entries kept.
- drop_flag clears only on rst.
- Outputs are registered. Latency: report visible on rpt_valid the cycle after the window-close cycle.
- rpt_alarm is computed at push time and stored with the count.
- Hold rule: rpt_count/rpt_alarm stay stable while rpt_valid=1 and rpt_ready=0.
- Reset mid-operation: everything cleared immediately, including pending reports; no partial report issued.

Test Plan:
- Normal window: WIN_LEN=16, en=1, rpt_ready=1, hit_in pulses at win_pos 3, 8, 12 -> one cycle after win_pos 15: rpt_valid=1 for 1 cycle, rpt_count=3, rpt_alarm=1.
- Boundary hits: hits at win_pos 15 and at the next window's win_pos 0 -> window 1 count=1, window 2 includes 1; with 2 hits total, THRESH=3 gives rpt_alarm=0 for both.
- Backpressure and drop: rpt_ready=0 over 3 windows with counts 1, 2, 4 -> buffer holds 1 then 2, count 4 dropped, drop_flag=1. Raising rpt_ready then delivers 1, then 2, in order; drop_flag remains 1.
- Simultaneous push/pop: buffer full, rpt_ready=1 in the window-close cycle -> the head pops and the new report is accepted, no drop; sequence intact.
- Saturation: CNT_W=4, WIN_LEN=32, hit_in held high all window -> rpt_count=15, not 0.
- Enable/reset mid-operation: en drops at win_pos 7 after 2 hits -> no report, win_pos=0; re-enable gives a fresh full window. Async rst pulse with 2 queued reports -> rpt_valid=0 and drop_flag=0 immediately, with no clock edge required.
